// File: rtl/prog_loader.sv
// prog_loader: writes the CPU program RAM from a framed UART byte stream.
//
// Frame: SYNC_BYTE, COUNT (1..16), COUNT instruction bytes, CSUM (sum mod 256 of the
// instruction bytes). Words go to addresses 0..COUNT-1 in order. The CPU is held in reset
// from the header until a frame is accepted; after a rejected frame it stays held.
//
// Ports
//   clk        system clock, rising edge
//   n_reset    asynchronous active-low reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle strobe per byte, may assert every cycle
//   mem_we     program RAM write enable (one-cycle pulse)
//   mem_addr   program RAM write address
//   mem_wdata  program RAM write data {op, imm}
//   cpu_hold   1 = keep CPU and PC in reset
//   busy       1 while a frame is in progress
//   load_done  one-cycle pulse, frame accepted
//   load_err   one-cycle pulse, frame rejected (bad count, bad checksum or timeout)
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000  // 0 disables the inter-byte timeout
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       load_done,
  output logic       load_err
);

  typedef enum logic [1:0] {StIdle, StCount, StData, StCsum} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;   // words in this frame, 1..16
  logic [4:0]  idx_q, idx_d;       // words written so far
  logic [7:0]  sum_q, sum_d;
  logic [31:0] tmo_q, tmo_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        tmo_hit;

  // Expires on the cycle that would bring the idle count up to TIMEOUT_CYCLES.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && ((tmo_q + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (state_q == StIdle || rx_valid || tmo_hit) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end

    case (state_q)
      StIdle: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d    = StCount;
          cpu_hold_d = 1'b1;
        end
      end
      StCount: begin
        if (rx_valid) begin
          if (rx_data != 8'd0 && rx_data <= 8'd16) begin
            count_d = rx_data[4:0];
            idx_d   = '0;
            sum_d   = '0;
            state_d = StData;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StData: begin
        if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[3:0];
          mem_wdata_d = rx_data;
          sum_d       = sum_q + rx_data;
          idx_d       = idx_q + 5'd1;
          if ((idx_q + 5'd1) == count_q) begin
            state_d = StCsum;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCsum: begin
        if (rx_valid) begin
          state_d = StIdle;
          if (rx_data == sum_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the stimulus pushes expected write/done/err events
// (with the cycle they must appear in); a monitor pops and compares on every DUT event.
module tb_prog_loader;

  localparam int KWrite = 0;
  localparam int KDone  = 1;
  localparam int KErr   = 2;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       load_done;
  logic       load_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
    int         stamp;
  } ev_t;

  ev_t sb[$];

  prog_loader #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one byte across the next rising edge; consecutive calls give back-to-back bytes.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after send(): the event must show up in the cycle just entered (+ offset).
  task automatic exp_ev(input int kind, input logic [3:0] a, input logic [7:0] d,
                        input int offs);
    ev_t e;
    e.kind  = kind;
    e.addr  = a;
    e.data  = d;
    e.stamp = cyc + offs;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (n_reset && (mem_we || load_done || load_err)) begin
        int  kind;
        ev_t e;
        checks++;
        if (int'(mem_we) + int'(load_done) + int'(load_err) > 1) begin
          errors++;
          $display("FAIL exclusive: we=%0b done=%0b err=%0b together (cycle %0d)",
                   mem_we, load_done, load_err, cyc);
        end else begin
          kind = mem_we ? KWrite : (load_done ? KDone : KErr);
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected event: kind %0d addr %0h data %0h, none expected (cycle %0d)",
                     kind, mem_addr, mem_wdata, cyc);
          end else begin
            e = sb.pop_front();
            if (kind != e.kind || e.stamp != cyc ||
                (kind == KWrite && (mem_addr !== e.addr || mem_wdata !== e.data))) begin
              errors++;
              $display("FAIL event: got kind %0d addr %0h data %0h cycle %0d, expected kind %0d addr %0h data %0h cycle %0d",
                       kind, mem_addr, mem_wdata, cyc, e.kind, e.addr, e.data, e.stamp);
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    #2 n_reset = 1'b0;
    #10;
    check("reset outputs", {18'd0, mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done,
                            load_err}, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    idle(2);

    // Good frame with gaps
    send(8'hA5);
    idle(1);
    check("hold after header", {31'd0, cpu_hold}, 32'd1);
    check("busy after header", {31'd0, busy}, 32'd1);
    send(8'h02);
    idle(1);
    send(8'h81); exp_ev(KWrite, 4'h0, 8'h81, 0);
    idle(1);
    send(8'h3F); exp_ev(KWrite, 4'h1, 8'h3F, 0);
    check("hold mid frame", {31'd0, cpu_hold}, 32'd1);
    idle(1);
    send(8'hC0); exp_ev(KDone, 4'h0, 8'h00, 0);
    check("hold released", {31'd0, cpu_hold}, 32'd0);
    check("idle after done", {31'd0, busy}, 32'd0);
    idle(2);

    // Bad checksum, then a good frame clears the hold
    send(8'hA5); send(8'h01);
    send(8'hB7); exp_ev(KWrite, 4'h0, 8'hB7, 0);
    send(8'h00); exp_ev(KErr, 4'h0, 8'h00, 0);
    idle(2);
    check("hold after bad csum", {31'd0, cpu_hold}, 32'd1);
    send(8'hA5); send(8'h01);
    send(8'h00); exp_ev(KWrite, 4'h0, 8'h00, 0);
    send(8'h00); exp_ev(KDone, 4'h0, 8'h00, 0);
    idle(1);
    check("hold after recovery", {31'd0, cpu_hold}, 32'd0);

    // Noise in idle, then bad counts 0 and 17
    send(8'h12); send(8'hFF);
    check("noise ignored", {30'd0, busy, cpu_hold}, 32'd0);
    send(8'hA5);
    send(8'h00); exp_ev(KErr, 4'h0, 8'h00, 0);
    idle(1);
    check("idle after count 0", {31'd0, busy}, 32'd0);
    check("hold after count 0", {31'd0, cpu_hold}, 32'd1);
    send(8'hA5);
    send(8'h11); exp_ev(KErr, 4'h0, 8'h00, 0);
    idle(2);

    // Full memory streamed, followed immediately by a frame whose data and csum equal SYNC
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      send(8'(i)); exp_ev(KWrite, 4'(i), 8'(i), 0);
    end
    send(8'h78); exp_ev(KDone, 4'h0, 8'h00, 0);
    send(8'hA5); send(8'h01);
    send(8'hA5); exp_ev(KWrite, 4'h0, 8'hA5, 0);
    send(8'hA5); exp_ev(KDone, 4'h0, 8'h00, 0);
    idle(1);
    check("hold after stream", {31'd0, cpu_hold}, 32'd0);

    // Timeout: 8 silent cycles after the last byte
    send(8'hA5); send(8'h03);
    send(8'h11); exp_ev(KWrite, 4'h0, 8'h11, 0);
    exp_ev(KErr, 4'h0, 8'h00, 8);
    idle(7);
    check("busy before timeout", {31'd0, busy}, 32'd1);
    idle(5);
    check("idle after timeout", {31'd0, busy}, 32'd0);
    check("hold after timeout", {31'd0, cpu_hold}, 32'd1);

    // Reset mid-frame
    send(8'hA5); send(8'h04);
    send(8'h10); exp_ev(KWrite, 4'h0, 8'h10, 0);
    send(8'h20); exp_ev(KWrite, 4'h1, 8'h20, 0);
    @(negedge clk);
    #1 n_reset = 1'b0;
    #1;
    check("async reset outputs", {18'd0, mem_we, mem_addr, mem_wdata, cpu_hold, busy,
                                  load_done, load_err}, 32'd0);
    idle(2);
    @(negedge clk);
    n_reset = 1'b1;
    idle(1);
    send(8'h33); send(8'h44);
    idle(2);
    check("ignore after reset", {30'd0, busy, cpu_hold}, 32'd0);
    idle(10);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the CPU's program memory: the CPU fetches an 8-bit instruction word ({op[3:0], imm[3:0]}) per address, and this block writes those words from a byte stream.
- Sits between the UART byte receiver and the 16-word program RAM write port.
- Accepts a framed download, writes words sequentially from address 0 and verifies a checksum.
- Holds the CPU in reset while a download is in progress or after a failed one.

Parameters:
- SYNC_BYTE, 8'hA5, frame header value.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte, valid when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per byte; may assert every cycle.
- mem_we  out  1  program RAM write enable, one-cycle pulse.
- mem_addr  out  4  program RAM write address.
- mem_wdata  out  8  program RAM write data, {op, imm}.
- cpu_hold  out  1  1 = keep CPU and PC in reset.
- busy  out  1  1 while a frame is in progress (state other than IDLE).
- load_done  out  1  one-cycle pulse: frame accepted.
- load_err  out  1  one-cycle pulse: frame rejected.

Behaviour:
- Frame format: SYNC_BYTE, COUNT, COUNT instruction bytes, CSUM. CSUM = 8-bit sum mod 256 of the instruction bytes only.
- Valid COUNT range is 8'h01..8'h10 (1..16 words).
- All outputs are registered. On reset: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, load_done=0, load_err=0, word counter=0, checksum accumulator=0, timeout counter=0.
- State machine: IDLE, COUNT, DATA, CSUM.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> COUNT, and cpu_hold=1 from the next cycle.
  - Any other byte is ignored; no outputs change.
- COUNT:
  - Byte in 1..16 -> latch the count, clear addr and sum, go to DATA.
  - Byte of 0 or >16 -> load_err pulse, go to IDLE.
- DATA:
  - Each rx_valid produces, on the next cycle: mem_we=1, mem_addr=word index, mem_wdata=rx_data. The sum accumulator adds rx_data.
  - After the COUNT-th byte -> CSUM.
  - The address increments after each write. It never wraps within a frame because COUNT ≤ 16; a COUNT of 16 writes addresses 0..15.
- CSUM:
  - Byte == accumulated sum -> load_done pulse, cpu_hold=0, go to IDLE.
  - Mismatch -> load_err pulse, cpu_hold stays 1, go to IDLE.
- cpu_hold:
  - After an error, cpu_hold stays 1 until the next successful frame. Words already written remain in RAM; there is no rollback.
  - A new header while cpu_hold=1 starts a fresh frame.
- Latency: load_done/load_err assert on the cycle after the terminating byte is sampled, and the state is IDLE in that same cycle.
- Back-to-back frames:
  - A byte arriving in the load_done/load_err cycle is processed by IDLE.
  - Back-to-back rx_valid (every cycle) is fully supported and gives one write per cycle.
- Timeout:
  - In COUNT, DATA and CSUM, the counter increments on each cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES -> load_err pulse, go to IDLE, cpu_hold stays 1.
  - In IDLE the counter is held at 0.
- A SYNC_BYTE value received inside a frame is treated as data, not as a resync.
- Reset mid-frame: everything returns to reset values immediately (asynchronous), including cpu_hold=0, and no further mem_we is issued.
- load_done and load_err are never asserted in the same cycle. mem_we never asserts outside DATA processing.

Test Plan:
- Good frame: A5,02,81,3F,C0 -> mem_we at addr 0 data 81, then addr 1 data 3F; load_done one cycle after C0; cpu_hold 1 from after A5 until load_done, then 0.
- Bad checksum: A5,01,B7,00 -> one write (addr 0, B7); load_err pulse; cpu_hold stays 1. A following good frame A5,01,00,00 -> load_done and cpu_hold=0.
- Bad count and noise: bytes 12,FF then A5,00 -> no writes, load_err after 00, state IDLE. Likewise A5,11 -> load_err.
- Full memory, back-to-back: A5,10 then 16 consecutive-cycle bytes 00..0F, then CSUM 78 -> 16 writes at addr 0..15 in consecutive cycles; load_done.
- Timeout with TIMEOUT_CYCLES=8: A5,03,11 then silence -> load_err exactly 8 idle cycles after the byte 11; busy=0 afterwards.
- Reset mid-frame: A5,04,10, then assert n_reset -> all outputs 0 immediately. After release, IDLE ignores the next non-A5 bytes.
